// File: rtl/ram_wb_arbiter.sv
// Two-master Wishbone-classic arbiter in front of a single-port RAM: round-robin grant,
// one strobe per access, local write acks, and a read-ack timeout that returns an error.
module ram_wb_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   // M0: instruction fetch
   input  logic                  m0_cyc,
   input  logic                  m0_stb,
   input  logic                  m0_we,
   input  logic [3:0]            m0_sel,
   input  logic [ADDR_WIDTH-1:0] m0_adr,
   input  logic [DATA_WIDTH-1:0] m0_dat_w,
   output logic [DATA_WIDTH-1:0] m0_dat_r,
   output logic                  m0_ack,
   output logic                  m0_err,
   // M1: load/store
   input  logic                  m1_cyc,
   input  logic                  m1_stb,
   input  logic                  m1_we,
   input  logic [3:0]            m1_sel,
   input  logic [ADDR_WIDTH-1:0] m1_adr,
   input  logic [DATA_WIDTH-1:0] m1_dat_w,
   output logic [DATA_WIDTH-1:0] m1_dat_r,
   output logic                  m1_ack,
   output logic                  m1_err,
   // RAM side
   output logic                  s_cyc,
   output logic                  s_stb,
   output logic                  s_we,
   output logic [3:0]            s_sel,
   output logic [ADDR_WIDTH-1:0] s_adr,
   output logic [DATA_WIDTH-1:0] s_dat_w,
   input  logic [DATA_WIDTH-1:0] s_dat_r,
   input  logic                  s_ack,
   // status
   output logic                  grant,
   output logic                  busy
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic                  grant_q, grant_d;
   logic                  we_q, we_d;
   logic [3:0]            sel_q, sel_d;
   logic [ADDR_WIDTH-1:0] adr_q, adr_d;
   logic [DATA_WIDTH-1:0] dat_w_q, dat_w_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   // Per-master views so the arbitration logic can index by master number
   logic [1:0]            req_v;
   logic [1:0]            cyc_v;
   logic [1:0]            we_v;
   logic [3:0]            sel_v   [2];
   logic [ADDR_WIDTH-1:0] adr_v   [2];
   logic [DATA_WIDTH-1:0] dat_w_v [2];
   logic [1:0]            ack_v;
   logic [1:0]            err_v;

   logic                  win;
   logic                  ack_any;
   logic                  err_any;

   assign cyc_v      = {m1_cyc, m0_cyc};
   assign req_v      = {m1_cyc & m1_stb, m0_cyc & m0_stb};
   assign we_v       = {m1_we, m0_we};
   assign sel_v[0]   = m0_sel;
   assign sel_v[1]   = m1_sel;
   assign adr_v[0]   = m0_adr;
   assign adr_v[1]   = m1_adr;
   assign dat_w_v[0] = m0_dat_w;
   assign dat_w_v[1] = m1_dat_w;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      we_d         = we_q;
      sel_d        = sel_q;
      adr_d        = adr_q;
      dat_w_d      = dat_w_q;
      cnt_d        = cnt_q;
      win          = 1'b0;
      ack_any      = 1'b0;
      err_any      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (|req_v) begin
               // On a tie the master that did not win last time goes first
               win          = (req_v[0] & req_v[1]) ? ~last_grant_q : req_v[1];
               grant_d      = win;
               last_grant_d = win;
               we_d         = we_v[win];
               sel_d        = sel_v[win];
               adr_d        = adr_v[win];
               dat_w_d      = dat_w_v[win];
               state_d      = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            cnt_d = '0;
            if (we_q) begin
               // The RAM never acks writes, so they complete on the strobe cycle
               ack_any = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (!cyc_v[grant_q]) begin
               state_d = ST_IDLE;
            end else if (s_ack) begin
               ack_any = 1'b1;
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               err_any = 1'b1;
               state_d = ST_IDLE;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         we_q         <= 1'b0;
         sel_q        <= '0;
         adr_q        <= '0;
         dat_w_q      <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         we_q         <= we_d;
         sel_q        <= sel_d;
         adr_q        <= adr_d;
         dat_w_q      <= dat_w_d;
         cnt_q        <= cnt_d;
      end
   end

   // Responses are steered only to the master that owns the bus
   for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      assign ack_v[gi] = ack_any & (grant_q == 1'(gi));
      assign err_v[gi] = err_any & (grant_q == 1'(gi));
   end

   assign m0_ack   = ack_v[0];
   assign m1_ack   = ack_v[1];
   assign m0_err   = err_v[0];
   assign m1_err   = err_v[1];
   assign m0_dat_r = s_dat_r;
   assign m1_dat_r = s_dat_r;

   assign s_cyc    = (state_q != ST_IDLE);
   assign s_stb    = (state_q == ST_ISSUE);
   assign s_we     = we_q;
   assign s_sel    = sel_q;
   assign s_adr    = adr_q;
   assign s_dat_w  = dat_w_q;

   assign grant    = grant_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ram_wb_arbiter.sv
// Bench for ram_wb_arbiter: directed scenarios plus randomized two-master traffic checked
// against a transaction-level model of grant order, ack/err timing and RAM contents.
module tb_ram_wb_arbiter;

   localparam int T = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        mcyc [2];
   logic        mstb [2];
   logic        mwe  [2];
   logic [3:0]  msel [2];
   logic [31:0] madr [2];
   logic [31:0] mdw  [2];
   logic [31:0] mdr  [2];
   logic        mack [2];
   logic        merr [2];

   logic        s_cyc, s_stb, s_we, s_ack;
   logic [3:0]  s_sel;
   logic [31:0] s_adr, s_dat_w, s_dat_r;
   logic        grant, busy;

   always #5 clk = ~clk;

   ram_wb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst),
      .m0_cyc(mcyc[0]), .m0_stb(mstb[0]), .m0_we(mwe[0]), .m0_sel(msel[0]),
      .m0_adr(madr[0]), .m0_dat_w(mdw[0]), .m0_dat_r(mdr[0]), .m0_ack(mack[0]), .m0_err(merr[0]),
      .m1_cyc(mcyc[1]), .m1_stb(mstb[1]), .m1_we(mwe[1]), .m1_sel(msel[1]),
      .m1_adr(madr[1]), .m1_dat_w(mdw[1]), .m1_dat_r(mdr[1]), .m1_ack(mack[1]), .m1_err(merr[1]),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel), .s_adr(s_adr),
      .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack),
      .grant(grant), .busy(busy)
   );

   // RAM stub: 16 words, combinational read, ack one (or two) cycles after a strobed read
   logic [31:0] ram [16];
   logic [1:0]  ack_pipe = 2'b00;
   logic        ack_en   = 1'b1;
   int          ack_lat  = 1;

   function automatic logic [31:0] init_word(input int i);
      if (i == 4) return 32'hDEADBEEF;
      return 32'hA5A50000 ^ (32'(i) * 32'h01010101);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
      end else if (s_cyc && s_stb && s_we) begin
         for (int b = 0; b < 4; b++)
            if (s_sel[b]) ram[s_adr[5:2]][8*b +: 8] <= s_dat_w[8*b +: 8];
      end
      ack_pipe <= {ack_pipe[0], s_cyc & s_stb & ~s_we & ack_en};
   end

   assign s_dat_r = ram[s_adr[5:2]];
   assign s_ack   = (ack_lat == 2) ? ack_pipe[1] : ack_pipe[0];

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic drive(input int n, input logic req, input logic we, input logic [3:0] sel,
                        input logic [31:0] adr, input logic [31:0] dat);
      mcyc[n] = req;
      mstb[n] = req;
      mwe[n]  = we;
      msel[n] = sel;
      madr[n] = adr;
      mdw[n]  = dat;
   endtask

   task automatic chk_idle_outputs(input string pfx);
      chk({pfx, "_s_cyc"}, s_cyc, 0);
      chk({pfx, "_s_stb"}, s_stb, 0);
      chk({pfx, "_s_we"}, s_we, 0);
      chk({pfx, "_s_sel"}, s_sel, 0);
      chk({pfx, "_s_adr"}, s_adr, 0);
      chk({pfx, "_s_dat_w"}, s_dat_w, 0);
      chk({pfx, "_grant"}, grant, 0);
      chk({pfx, "_busy"}, busy, 0);
      chk({pfx, "_acks"}, {mack[0], mack[1], merr[0], merr[1]}, 0);
   endtask

   // One complete access by a single master on an otherwise quiet bus
   task automatic single(input int n, input logic we, input logic [3:0] sel,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [31:0] exp_rd);
      @(posedge clk); #1 drive(n, 1'b1, we, sel, adr, dat);
      @(posedge clk);
      @(negedge clk);
      chk("sg_s_stb", s_stb, 1);
      chk("sg_s_adr", s_adr, adr);
      chk("sg_s_we", s_we, we);
      chk("sg_s_sel", s_sel, sel);
      chk("sg_grant", grant, n[0]);
      if (we) chk("sg_s_dat_w", s_dat_w, dat);
      chk("sg_ack_issue", mack[n], we);
      chk("sg_ack_other", mack[1-n], 0);
      if (!we) begin
         @(negedge clk);
         chk("sg_stb_wait", s_stb, 0);
         chk("sg_cyc_wait", s_cyc, 1);
         chk("sg_ack_wait", mack[n], 1);
         chk("sg_rdata", mdr[n], exp_rd);
      end
      @(posedge clk); #1 drive(n, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk("sg_busy_after", busy, 0);
      chk("sg_ack_after", mack[n], 0);
   endtask

   // Transaction-level model: an access granted at edge k acks after edge k (write) or k+1 (read);
   // the arbiter next looks at requests two edges after the ack.
   int          cyc_no = 0;
   int          next_free, issue_cyc, ack_cyc, own;
   logic        own_we, last_g;
   logic [31:0] own_adr, exp_data;
   logic [31:0] ref_mem [16];
   bit          act [2];
   bit          done_m [2];
   int          rq_pct, wr_pct;
   int          obs_log [$];

   task automatic model_sync();
      next_free = cyc_no;
      issue_cyc = -100;
      ack_cyc   = -100;
      own       = 0;
      last_g    = 1'b1;
      for (int i = 0; i < 16; i++) ref_mem[i] = ram[i];
      for (int n = 0; n < 2; n++) begin
         act[n]    = 0;
         done_m[n] = 0;
      end
   endtask

   task automatic step();
      logic r0, r1, e;
      int w;
      @(posedge clk);
      cyc_no++;
      r0 = mcyc[0] & mstb[0];
      r1 = mcyc[1] & mstb[1];
      if (cyc_no >= next_free && (r0 || r1)) begin
         w         = (r0 && r1) ? (last_g ? 0 : 1) : (r0 ? 0 : 1);
         last_g    = w[0];
         own       = w;
         own_we    = mwe[w];
         own_adr   = madr[w];
         issue_cyc = cyc_no;
         ack_cyc   = own_we ? cyc_no : cyc_no + 1;
         next_free = ack_cyc + 2;
         if (own_we) begin
            for (int b = 0; b < 4; b++)
               if (msel[w][b]) ref_mem[madr[w][5:2]][8*b +: 8] = mdw[w][8*b +: 8];
         end else begin
            exp_data = ref_mem[madr[w][5:2]];
         end
      end
      #1;
      for (int n = 0; n < 2; n++) begin
         if (done_m[n]) begin
            drive(n, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            done_m[n] = 0;
            act[n]    = 0;
         end else if (!act[n] && int'($urandom_range(99)) < rq_pct) begin
            logic we_r;
            we_r = int'($urandom_range(99)) < wr_pct;
            drive(n, 1'b1, we_r, we_r ? 4'($urandom_range(15, 1)) : 4'hF,
                  32'($urandom_range(63)), $urandom);
            act[n] = 1;
         end
      end
      @(negedge clk);
      chk("rn_busy", busy, (cyc_no >= issue_cyc) && (cyc_no <= ack_cyc));
      chk("rn_stb", s_stb, cyc_no == issue_cyc);
      if (cyc_no >= issue_cyc && cyc_no <= ack_cyc) chk("rn_grant", grant, own[0]);
      if (cyc_no == issue_cyc) begin
         chk("rn_s_adr", s_adr, own_adr);
         chk("rn_s_we", s_we, own_we);
      end
      if (s_stb) obs_log.push_back(int'(grant));
      for (int n = 0; n < 2; n++) begin
         e = (cyc_no == ack_cyc) && (own == n);
         chk(n == 0 ? "rn_ack0" : "rn_ack1", mack[n], e);
         chk(n == 0 ? "rn_err0" : "rn_err1", merr[n], 0);
         if (e && !own_we) chk("rn_rdata", mdr[n], exp_data);
         if (e) done_m[n] = 1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int n = 0; n < 2; n++) drive(n, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_idle_outputs("reset");
      rst = 1'b0;

      // Single read, byte write into the top byte, readback
      single(1, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF);
      single(1, 1'b1, 4'b1000, 32'h13, 32'hAB000000, 32'h0);
      single(1, 1'b0, 4'hF, 32'h10, 32'h0, 32'hABADBEEF);

      // Timeout: the RAM never acks, the error lands TIMEOUT_CYCLES cycles into WAIT
      ack_en = 1'b0;
      @(posedge clk); #1 drive(0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
      @(posedge clk);
      @(negedge clk);
      chk("to_stb", s_stb, 1);
      for (int i = 1; i <= T; i++) begin
         @(negedge clk);
         chk("to_err", merr[0], i == T);
         chk("to_ack", mack[0], 0);
         chk("to_busy", busy, 1);
      end
      @(posedge clk); #1 drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk("to_busy_after", busy, 0);
      chk("to_err_after", merr[0], 0);
      ack_en = 1'b1;

      // Abort: M0 drops cyc in WAIT, a late ack follows, pending M1 is served next
      ack_lat = 2;
      @(posedge clk); #1 drive(0, 1'b1, 1'b0, 4'hF, 32'h08, 32'h0);
      @(posedge clk); #1 drive(1, 1'b1, 1'b0, 4'hF, 32'h0C, 32'h0);
      @(negedge clk);
      chk("ab_grant0", grant, 0);
      chk("ab_stb0", s_stb, 1);
      @(posedge clk); #1 drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk("ab_wait_ack0", mack[0], 0);
      chk("ab_wait_err0", merr[0], 0);
      @(negedge clk);
      chk("ab_late_ack0", mack[0], 0);
      chk("ab_late_ack1", mack[1], 0);
      chk("ab_late_busy", busy, 0);
      @(posedge clk); #1 ack_lat = 1;
      @(negedge clk);
      chk("ab_grant1", grant, 1);
      chk("ab_stb1", s_stb, 1);
      @(negedge clk);
      chk("ab_ack1", mack[1], 1);
      chk("ab_ack0", mack[0], 0);
      chk("ab_rdata1", mdr[1], init_word(3));
      @(posedge clk); #1 drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

      // Asynchronous reset in the middle of a read wait
      ack_en = 1'b0;
      @(posedge clk); #1 drive(1, 1'b1, 1'b0, 4'hF, 32'h24, 32'h0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("ar_pre_busy", busy, 1);
      chk("ar_pre_grant", grant, 1);
      #2 rst = 1'b1;
      #1 chk_idle_outputs("async_rst");
      drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst    = 1'b0;
      ack_en = 1'b1;

      // Tie: both masters keep requesting reads; grants must alternate starting with M0
      model_sync();
      rq_pct = 100;
      wr_pct = 0;
      obs_log.delete();
      for (int i = 0; i < 60 && obs_log.size() < 6; i++) step();
      chk("tie_count", obs_log.size() >= 6, 1);
      for (int i = 0; i < 6 && i < obs_log.size(); i++)
         chk($sformatf("tie_grant%0d", i), obs_log[i], i % 2);

      // Randomized mixed traffic
      rq_pct = 50;
      wr_pct = 40;
      repeat (400) step();
      for (int n = 0; n < 2; n++) drive(n, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      repeat (4) @(posedge clk);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
